cache_ctrl: RTL

//  Direct-mapped, read-only cache controller inside the memory-system Top. It accepts byte-read

---
 rtl/cache_pkg.sv | 17 +
 rtl/cache_if.sv | 26 ++
 rtl/cache_line_store.sv | 36 +++
 rtl/cache_ctrl.sv | 88 ++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: shared widths and state encoding for the direct-mapped cache
package cache_pkg;
    localparam int ADDR_W      = 10;
    localparam int INDEX_W     = 3;
    localparam int OFFSET_W    = 2;
    localparam int DATA_W      = 8;
    localparam int TAG_W       = ADDR_W - INDEX_W - OFFSET_W;
    localparam int BLOCK_WORDS = 2 ** OFFSET_W;
    localparam int LINES       = 2 ** INDEX_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOOKUP  = 2'd1,
        REFILL  = 2'd2,
        RESPOND = 2'd3
    } state_t;
endpackage

// File: rtl/cache_if.sv
// cache_if: request/response and refill bus of the cache controller
interface cache_if #(parameter int CNT_W = 16);
    import cache_pkg::*;
    logic                       req_valid;
    logic [ADDR_W-1:0]          req_addr;
    logic                       req_ready;
    logic                       resp_valid;
    logic [DATA_W-1:0]          resp_data;
    logic                       hit;
    logic                       mem_rd_req;
    logic [ADDR_W-OFFSET_W-1:0] mem_addr;
    logic                       mem_rd_valid;
    logic [DATA_W-1:0]          mem_rd_data;
    logic [CNT_W-1:0]           hit_count;
    logic [CNT_W-1:0]           miss_count;

    modport master (
        output req_valid, req_addr, mem_rd_valid, mem_rd_data,
        input  req_ready, resp_valid, resp_data, hit, mem_rd_req, mem_addr, hit_count, miss_count
    );

    modport slave (
        input  req_valid, req_addr, mem_rd_valid, mem_rd_data,
        output req_ready, resp_valid, resp_data, hit, mem_rd_req, mem_addr, hit_count, miss_count
    );
endinterface

// File: rtl/cache_line_store.sv
// cache_line_store: valid, tag and data arrays with combinational lookup
module cache_line_store
    import cache_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [INDEX_W-1:0]  idx,
    input  logic [TAG_W-1:0]    tag,
    input  logic [OFFSET_W-1:0] off,
    input  logic                inval,
    input  logic                wr_en,
    input  logic                wr_last,
    input  logic [OFFSET_W-1:0] wr_off,
    input  logic [DATA_W-1:0]   wr_data,
    output logic                hit,
    output logic [DATA_W-1:0]   rd_data
);
    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tags [LINES];
    logic [DATA_W-1:0] data [LINES][BLOCK_WORDS];

    assign hit     = valid[idx] && (tags[idx] == tag);
    assign rd_data = data[idx][off];

    // valid bits: dropped when a refill starts, set once the last beat lands
    always_ff @(posedge clk or posedge rst)
        if (rst) valid <= '0;
        else if (inval) valid[idx] <= 1'b0;
        else if (wr_last) valid[idx] <= 1'b1;

    // tag and data storage, never cleared by reset
    always_ff @(posedge clk) begin
        if (wr_en) data[idx][wr_off] <= wr_data;
        if (wr_last) tags[idx] <= tag;
    end
endmodule

// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped read-only cache FSM with block refill and saturating stats
module cache_ctrl
    import cache_pkg::*;
(
    input logic clk,
    input logic rst,
    cache_if.slave bus
);
    state_t              state;
    logic [ADDR_W-1:0]   addr;
    logic [OFFSET_W-1:0] beat;
    logic                lk_hit;
    logic [DATA_W-1:0]   rd_data;
    logic                wr_en;

    wire [INDEX_W-1:0]  idx = addr[OFFSET_W +: INDEX_W];
    wire [OFFSET_W-1:0] off = addr[OFFSET_W-1:0];
    wire [TAG_W-1:0]    tag = addr[ADDR_W-1 -: TAG_W];

    assign bus.req_ready = (state == IDLE);
    assign wr_en         = (state == REFILL) && bus.mem_rd_valid;

    cache_line_store u_store (
        .clk     (clk),
        .rst     (rst),
        .idx     (idx),
        .tag     (tag),
        .off     (off),
        .inval   ((state == LOOKUP) && !lk_hit),
        .wr_en   (wr_en),
        .wr_last (wr_en && (&beat)),
        .wr_off  (beat),
        .wr_data (bus.mem_rd_data),
        .hit     (lk_hit),
        .rd_data (rd_data)
    );

    // controller FSM with registered response, refill request and statistics
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            addr           <= '0;
            beat           <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_data  <= '0;
            bus.hit        <= 1'b0;
            bus.mem_rd_req <= 1'b0;
            bus.mem_addr   <= '0;
            bus.hit_count  <= '0;
            bus.miss_count <= '0;
        end else begin
            bus.resp_valid <= 1'b0;
            bus.mem_rd_req <= 1'b0;
            case (state)
                IDLE:
                    if (bus.req_valid) begin
                        addr  <= bus.req_addr;
                        state <= LOOKUP;
                    end
                LOOKUP:
                    if (lk_hit) begin
                        bus.resp_valid <= 1'b1;
                        bus.hit        <= 1'b1;
                        bus.resp_data  <= rd_data;
                        if (!(&bus.hit_count)) bus.hit_count <= bus.hit_count + 1'b1;
                        state <= IDLE;
                    end else begin
                        bus.mem_rd_req <= 1'b1;
                        bus.mem_addr   <= addr[ADDR_W-1:OFFSET_W];
                        if (!(&bus.miss_count)) bus.miss_count <= bus.miss_count + 1'b1;
                        beat  <= '0;
                        state <= REFILL;
                    end
                REFILL:
                    if (bus.mem_rd_valid) begin
                        beat <= beat + 1'b1;
                        if (&beat) state <= RESPOND;
                    end
                RESPOND: begin
                    bus.resp_valid <= 1'b1;
                    bus.hit        <= 1'b0;
                    bus.resp_data  <= rd_data;
                    state          <= IDLE;
                end
            endcase
        end
    end
endmodule
